mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width.
REQ-002 SHALL have parameter DEPTH, default 256: number of words in the attached memory.
REQ-003 SHALL have parameter ABITS, default $clog2(DEPTH): address width.
REQ-004 SHALL have port clock  input  1  sole clock; one clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  datapath request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_address  input  ABITS  word address (MAR value).
REQ-010 SHALL have port req_wdata  input  WIDTH  write data (MDR value).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  datapath consumes the response.
REQ-013 SHALL have port rsp_rdata  output  WIDTH  read data, or echoed write data.
REQ-014 SHALL have port rsp_error  output  1  request address >= DEPTH.
REQ-015 SHALL have port mem_read  output  1  memory read strobe.
REQ-016 SHALL have port mem_write  output  1  memory write strobe.
REQ-017 SHALL have port mem_address  output  ABITS  memory address.
REQ-018 SHALL have port mem_write_data  output  WIDTH  memory write data.
REQ-019 SHALL have port mem_read_data  input  WIDTH  memory read data, registered with 1-cycle latency after mem_read.
REQ-020 SHALL have port stat_count  output  48  {err[15:0], wr[15:0], rd[15:0]} statistics.

Function
REQ-021 SHALL implement FSM states IDLE, RD, CAP, WR, RSP.
REQ-022 SHALL drive req_ready = 1 only in IDLE; acceptance is req_valid && req_ready, which latches req_write, req_address and req_wdata.
REQ-023 SHALL transition on acceptance (cycle 0) as follows: address >= DEPTH -> RSP; read -> RD; write -> WR.
REQ-024 SHALL assert mem_read only in RD, lasting exactly one cycle, then go to CAP.
REQ-025 SHALL capture mem_read_data into the MDR register at the end of CAP, then go to RSP; first read rsp_valid occurs in cycle 3.
REQ-026 SHALL assert mem_write only in WR, lasting exactly one cycle, load MDR with the latched write data, then go to RSP; first write rsp_valid occurs in cycle 2.
REQ-027 SHALL keep mem_address and mem_write_data equal to the latched request at all times; mem_read and mem_write SHALL never both be 1.
REQ-028 SHALL, on an out-of-range address, issue no memory strobe, set MDR = 0 and rsp_error = 1; first rsp_valid occurs in cycle 1.
REQ-029 SHALL, in RSP, hold rsp_valid = 1 with rsp_rdata = MDR and rsp_error stable until rsp_ready; on handshake, go to IDLE.
REQ-030 SHALL deassert rsp_error in every state other than RSP.
REQ-031 SHALL make req_ready high in the cycle after a response handshake; a request SHALL NOT be accepted in the handshake cycle itself.
REQ-032 SHALL ignore req_valid, and leave latched fields unchanged, while not in IDLE.

Reset
REQ-033 SHALL, on reset assertion, immediately force state IDLE, MDR 0, latched address/data/write 0 and counters 0, without waiting for a clock edge.
REQ-034 SHALL, on reset mid-transaction, drop the transaction with no response; mem_read, mem_write, rsp_valid and rsp_error SHALL be 0 while reset is high.

Configuration
REQ-035 SHALL, with macro MEM_CTRL_STATS_EN defined, count read handshakes (rd), write handshakes (wr) and error handshakes (err), each as a 16-bit counter saturating at 0xFFFF, counting at the rsp handshake; an error counts only in err.
REQ-036 SHALL, without MEM_CTRL_STATS_EN, contain no counter logic and tie stat_count to 0.

Verification
REQ-037 SHALL cover: write addr 0x10 data 0xDEADBEEF -> mem_write high exactly in cycle 1 with mem_address=0x10; rsp_valid in cycle 2 with rsp_rdata=0xDEADBEEF and rsp_error=0.
REQ-038 SHALL cover: read addr 0x10 after REQ-037 -> mem_read high exactly in cycle 1; rsp_valid in cycle 3 with rsp_rdata=0xDEADBEEF.
REQ-039 SHALL cover: DEPTH=200 with read addr 0xC8 -> no strobe; rsp_valid in cycle 1 with rsp_error=1 and rsp_rdata=0.
REQ-040 SHALL cover: rsp_ready held 0 for 5 cycles, with req_valid held 1 and a new address -> rsp_valid and rsp_rdata stable throughout, req_ready stays 0, and the second request is accepted only after the handshake.
REQ-041 SHALL cover: reset asserted in state CAP -> mem_read=0, rsp_valid=0 and req_ready=1 immediately after release; no response produced.
REQ-042 SHALL cover: with MEM_CTRL_STATS_EN, 2 writes, 3 reads and 1 error -> stat_count = {16'd1, 16'd2, 16'd3}; without the macro -> stat_count = 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller sequencing MAR/MDR requests onto a 1-cycle-latency memory.
// Optional handshake statistics counters are enabled with MEM_CTRL_STATS_EN.
module mem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ABITS = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ABITS-1:0] req_address,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_error,
  output logic             mem_read,
  output logic             mem_write,
  output logic [ABITS-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic [47:0]      stat_count
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, RSP
  } state_t;

  state_t state_q, state_d;

  logic             wr_q;
  logic             err_q;
  logic [ABITS-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] mdr_q;
  logic             accept;
  logic             oor;
  logic             rsp_hs;

  // Address wider than the array can still be representable in ABITS bits
  assign oor = 32'(req_address) >= 32'(DEPTH);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rsp_hs  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (oor)
            state_d = RSP;
          else if (req_write)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: state_d = RSP;
      WR:  state_d = RSP;
      RSP: begin
        if (rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= oor;
        addr_q  <= req_address;
        wdata_q <= req_wdata;
        if (oor)
          mdr_q <= '0;
      end
      if (state_q == CAP)
        mdr_q <= mem_read_data;
      if (state_q == WR)
        mdr_q <= wdata_q;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign mem_read       = (state_q == RD);
  assign mem_write      = (state_q == WR);
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp_valid      = (state_q == RSP);
  assign rsp_error      = (state_q == RSP) && err_q;
  assign rsp_rdata      = mdr_q;

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] rd_c, wr_c, err_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_c  <= '0;
      wr_c  <= '0;
      err_c <= '0;
    end else if (rsp_hs) begin
      if (err_q) begin
        if (err_c != 16'hFFFF) err_c <= err_c + 16'd1;
      end else if (wr_q) begin
        if (wr_c != 16'hFFFF) wr_c <= wr_c + 16'd1;
      end else begin
        if (rd_c != 16'hFFFF) rd_c <= rd_c + 16'd1;
      end
    end
  end

  assign stat_count = {err_c, wr_c, rd_c};
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl (DEPTH=200) with a registered memory model.
// Inputs change at the falling edge; outputs are checked 1 ns later.
module tb_mem_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 200;
  localparam int ABITS = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ABITS-1:0] req_address;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_error;
  logic             mem_read;
  logic             mem_write;
  logic [ABITS-1:0] mem_address;
  logic [WIDTH-1:0] mem_write_data;
  logic [WIDTH-1:0] mem_read_data;
  logic [47:0]      stat_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem [0:255];
  logic [47:0] exp_stat;

  always #5 clock = ~clock;

  mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ABITS(ABITS)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_address(req_address),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .stat_count(stat_count)
  );

  always_ff @(posedge clock) begin
    if (mem_write)
      mem[mem_address] <= mem_write_data;
    if (mem_read)
      mem_read_data <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic req(input logic w, input logic [ABITS-1:0] a,
                     input logic [WIDTH-1:0] d);
    req_valid   = 1'b1;
    req_write   = w;
    req_address = a;
    req_wdata   = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_read_data = '0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_address = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_stat", 64'(stat_count), 64'd0);
    step(); reset = 1'b0;

    // reset while in CAP drops the read
    step(); req(1'b0, 8'h10, 32'h0);
    #1 chk("rt_c0_ready", 64'(req_ready), 64'd1);
    step(); req_valid = 1'b0;
    #1 chk("rt_c1_mem_read", 64'(mem_read), 64'd1);
    step();
    #1 chk("rt_c2_mem_read", 64'(mem_read), 64'd0);
    reset = 1'b1;
    #1 chk("rt_in_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rt_in_mem_read", 64'(mem_read), 64'd0);
    chk("rt_in_rsp_error", 64'(rsp_error), 64'd0);
    step(); step(); reset = 1'b0;
    #1 chk("rt_rel_ready", 64'(req_ready), 64'd1);
    chk("rt_rel_mem_read", 64'(mem_read), 64'd0);
    chk("rt_rel_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) step();
    #1 chk("rt_noresp", 64'(rsp_valid), 64'd0);

    // write 0x10
    step(); req(1'b1, 8'h10, 32'hDEADBEEF);
    #1 chk("w_c0_ready", 64'(req_ready), 64'd1);
    chk("w_c0_mem_write", 64'(mem_write), 64'd0);
    step(); req_valid = 1'b0;
    #1 chk("w_c1_mem_write", 64'(mem_write), 64'd1);
    chk("w_c1_mem_read", 64'(mem_read), 64'd0);
    chk("w_c1_addr", 64'(mem_address), 64'h10);
    chk("w_c1_wdata", 64'(mem_write_data), 64'hDEADBEEF);
    chk("w_c1_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    #1 chk("w_c2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("w_c2_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("w_c2_error", 64'(rsp_error), 64'd0);
    chk("w_c2_mem_write", 64'(mem_write), 64'd0);
    step();
    #1 chk("w_c3_ready", 64'(req_ready), 64'd1);

    // read 0x10
    step(); req(1'b0, 8'h10, 32'h0);
    step(); req_valid = 1'b0;
    #1 chk("r_c1_mem_read", 64'(mem_read), 64'd1);
    chk("r_c1_mem_write", 64'(mem_write), 64'd0);
    chk("r_c1_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    #1 chk("r_c2_mem_read", 64'(mem_read), 64'd0);
    chk("r_c2_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    #1 chk("r_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("r_c3_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("r_c3_error", 64'(rsp_error), 64'd0);

    // response back-pressure with a pending second request
    step(); rsp_ready = 1'b0; req(1'b1, 8'h20, 32'h12345678);
    step(); req_valid = 1'b0;
    #1 chk("s_c1_mem_write", 64'(mem_write), 64'd1);
    step(); req(1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("s_hold_valid", 64'(rsp_valid), 64'd1);
      chk("s_hold_rdata", 64'(rsp_rdata), 64'h12345678);
      chk("s_hold_ready", 64'(req_ready), 64'd0);
      chk("s_hold_addr", 64'(mem_address), 64'h20);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("s_hs_valid", 64'(rsp_valid), 64'd1);
    chk("s_hs_ready", 64'(req_ready), 64'd0);
    step();
    #1 chk("s_idle_ready", 64'(req_ready), 64'd1);
    chk("s_idle_valid", 64'(rsp_valid), 64'd0);
    step(); req_valid = 1'b0;
    #1 chk("s2_c1_mem_read", 64'(mem_read), 64'd1);
    chk("s2_c1_addr", 64'(mem_address), 64'h10);
    step(); step();
    #1 chk("s2_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("s2_c3_rdata", 64'(rsp_rdata), 64'hDEADBEEF);

    // read back 0x20
    step(); req(1'b0, 8'h20, 32'h0);
    step(); req_valid = 1'b0;
    step(); step();
    #1 chk("r20_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("r20_rdata", 64'(rsp_rdata), 64'h12345678);

    // out-of-range address
    step(); req(1'b0, 8'hC8, 32'h0);
    step(); req_valid = 1'b0;
    #1 chk("e_c1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("e_c1_error", 64'(rsp_error), 64'd1);
    chk("e_c1_rdata", 64'(rsp_rdata), 64'd0);
    chk("e_c1_mem_read", 64'(mem_read), 64'd0);
    chk("e_c1_mem_write", 64'(mem_write), 64'd0);
    step();
    #1 chk("e_c2_error", 64'(rsp_error), 64'd0);
    chk("e_c2_ready", 64'(req_ready), 64'd1);

`ifdef MEM_CTRL_STATS_EN
    exp_stat = {16'd1, 16'd2, 16'd3};
`else
    exp_stat = 48'd0;
`endif
    step();
    #1 chk("stat_count", 64'(stat_count), 64'(exp_stat));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
